data_mem: RTL
=============

# data_mem

Parametrised byte-addressed data memory with a request/done handshake and configurable access latency. It is the successor to the single-cycle combinational-read RAM and serves the memory stage of the MIPS datapath. It supports byte, halfword and word accesses with signed or unsigned extension, and it detects misaligned and out-of-range accesses. Storage is little-endian: the byte at `address` lands in `dataOut[7:0]`.

## Interface

- `DEPTH`, 256: memory size in bytes; must be a power of two, from 4 to 2^27.
- `WAIT`, 2: wait cycles inserted between accept and completion; legal range 0..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only while `ready`=1.
- `write`  in  1  1 = store, 0 = load.
- `size`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `sign`  in  1  load extension: 1 = sign-extend, 0 = zero-extend; ignored for word accesses and stores.
- `address`  in  32  byte address.
- `dataIn`  in  32  store data; the low 1/2/4 bytes are used, according to `size`.
- `ready`  out  1  block is idle and can accept a request.
- `done`  out  1  one-cycle completion pulse.
- `dataOut`  out  32  load result; holds its value until the next completed load.
- `error`  out  1  qualifies `done`: the access was illegal and was not performed.

## Operation

- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - `ready`=1.
  - On an edge with `req`=1, latch `write`, `size`, `sign`, `address` and `dataIn`, load `cnt`=WAIT, and go to BUSY.
- BUSY:
  - `ready`=0. Input changes have no effect; `req` is ignored.
  - If `cnt`≠0, decrement it.
  - On the edge where `cnt`=0, perform the access and go to DONE.
- DONE:
  - `done`=1 and `error` is valid for exactly this cycle.
  - Next edge returns to IDLE.
- Illegal access conditions; any one of these makes the access illegal:
  - `size`=11.
  - Half access with `address[0]`=1.
  - Word access with `address[1:0]`≠00.
  - `address` ≥ DEPTH. Checked on the full 32 bits, so an address never wraps.
- Illegal access handling:
  - Memory is unchanged and `dataOut` is forced to 0.
  - `error`=1 during DONE.
  - The full latency is still observed.
- Store:
  - Writes only the addressed 1, 2 or 4 bytes.
  - Byte k of `dataIn` goes to `address`+k.
  - All other bytes are preserved.
- Load:
  - Byte: `dataOut` = {24{`sign`&b0[7]}, b0}.
  - Half: `dataOut` = {16{`sign`&b1[7]}, b1, b0}.
  - Word: `dataOut` = {b3, b2, b1, b0}.
  - bk = the byte at `address`+k.
- A store leaves `dataOut` unchanged.
- Memory contents are not reset; they are undefined until written.

## Timing

- Reset values:
  - `ready`=1, `done`=0, `error`=0, `dataOut`=0, `cnt`=0, state IDLE.
- Latency:
  - Let the accepting edge be edge 0.
  - The access is performed at edge WAIT+1.
  - `done` is high in the cycle after edge WAIT+1.
  - `ready` rises one cycle after `done`.
  - Minimum request spacing is therefore WAIT+3 cycles.
- WAIT=0: the access happens on the first edge after accept.
- `done`/`error` are registered outputs; they have no combinational path from the inputs.
- `dataOut` updates on the same edge that raises `done`.
- Reset asserted in BUSY or DONE:
  - The FSM returns to IDLE immediately.
  - A pending store is discarded; memory is untouched.
  - No `done` pulse is produced.
- `req` held high continuously: a new request is accepted on every IDLE edge, back-to-back at WAIT+3 spacing.

## Test plan

- Reset check: assert `rst_n`=0 mid-cycle. Outputs go to `ready`=1, `done`=0, `error`=0, `dataOut`=0 without waiting for a clock edge.
- Word round-trip, WAIT=2:
  - Store 0xF00FF176 at address 200.
  - Then load a word from 200.
  - Required: `done` is high exactly 3 edges after each accept, `dataOut`=0xF00FF176, `error`=0.
- Extension:
  - Half load from 200, signed → 0xFFFFF176; unsigned → 0x0000F176.
  - Byte load from 203, signed → 0xFFFFFFF0.
  - Byte load from 201, unsigned → 0x000000F1.
- Partial store: store byte 0xAA at address 201, then load a word from 200 → 0xF00FAA76.
- Errors:
  - Word store at 202, half load at 201, size=11, and word load at 256 (DEPTH=256).
  - Required for each: `done`=1 with `error`=1, `dataOut`=0.
  - A following word load from 200 still returns 0xF00FAA76.
- Protocol and reset:
  - Pulse `req` and change `address` during BUSY → no extra `done`, and the result uses the latched address.
  - Accept a word store of 0x12345678 at 200, then assert `rst_n` during BUSY. No `done` is produced, and a later load from 200 still returns 0xF00FAA76.

Source files
------------

// File: rtl/data_mem.sv
// Byte-addressed data memory with a req/done handshake and WAIT-cycle access latency.
// Little-endian byte, half and word accesses; illegal accesses complete with error and no side effects.
module data_mem #(
   parameter int DEPTH = 256,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        write,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] address,
   input  logic [31:0] dataIn,
   output logic        ready,
   output logic        done,
   output logic [31:0] dataOut,
   output logic        error
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          write_q;
   logic [1:0]    size_q;
   logic          sign_q;
   logic [31:0]   addr_q;
   logic [31:0]   data_q;
   logic          done_q;
   logic          error_q;
   logic [31:0]   dataOut_q;

   logic [7:0]    mem [DEPTH];

   logic          legal_d;
   logic          memWe_d;
   logic [AW-1:0] base_d;
   logic [7:0]    b0_d, b1_d, b2_d, b3_d;
   logic [31:0]   loadData_d;

   assign ready   = (state_q == IDLE);
   assign done    = done_q;
   assign error   = error_q;
   assign dataOut = dataOut_q;

   // Range is checked on all 32 address bits so an out-of-range address never aliases.
   always_comb begin
      legal_d = 1'b1;
      case (size_q)
         2'b00:   legal_d = 1'b1;
         2'b01:   legal_d = ~addr_q[0];
         2'b10:   legal_d = (addr_q[1:0] == 2'b00);
         default: legal_d = 1'b0;
      endcase
      if (addr_q >= 32'(DEPTH)) legal_d = 1'b0;
   end

   always_comb begin
      base_d     = addr_q[AW-1:0];
      b0_d       = mem[base_d];
      b1_d       = mem[base_d + AW'(1)];
      b2_d       = mem[base_d + AW'(2)];
      b3_d       = mem[base_d + AW'(3)];
      loadData_d = {b3_d, b2_d, b1_d, b0_d};
      case (size_q)
         2'b00:   loadData_d = {{24{sign_q & b0_d[7]}}, b0_d};
         2'b01:   loadData_d = {{16{sign_q & b1_d[7]}}, b1_d, b0_d};
         default: loadData_d = {b3_d, b2_d, b1_d, b0_d};
      endcase
   end

   assign memWe_d = (state_q == BUSY) && (cnt_q == 4'd0) && write_q && legal_d;

   // Storage has no reset; only the addressed byte lanes are written.
   always_ff @(posedge clk) begin
      if (memWe_d) begin
         mem[base_d] <= data_q[7:0];
         if (size_q != 2'b00) mem[base_d + AW'(1)] <= data_q[15:8];
         if (size_q == 2'b10) begin
            mem[base_d + AW'(2)] <= data_q[23:16];
            mem[base_d + AW'(3)] <= data_q[31:24];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         write_q   <= 1'b0;
         size_q    <= 2'b00;
         sign_q    <= 1'b0;
         addr_q    <= 32'h0;
         data_q    <= 32'h0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         dataOut_q <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q  <= 1'b0;
               error_q <= 1'b0;
               if (req) begin
                  write_q <= write;
                  size_q  <= size;
                  sign_q  <= sign;
                  addr_q  <= address;
                  data_q  <= dataIn;
                  cnt_q   <= 4'(WAIT);
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  error_q <= ~legal_d;
                  if (!legal_d)     dataOut_q <= 32'h0;
                  else if (!write_q) dataOut_q <= loadData_d;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               error_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               error_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
